// File: rtl/trade_pkg.sv
// Shared types and widths for the trade order path: sides, FSM encoding and
// the lot cost helper used by both the order FSM and the position ledger.
package trade_pkg;

    localparam int NUM_STOCKS = 4;
    localparam int ID_W       = 2;
    localparam int PRICE_W    = 14;
    localparam int CASH_W     = 32;
    localparam int POS_W      = 4;
    localparam int CD_W       = 8;
    localparam int CNT_W      = 16;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    function automatic logic [CASH_W-1:0] lot_cost(input logic [PRICE_W-1:0] price,
                                                   input logic [CASH_W-1:0]  lot);
        return CASH_W'(price) * lot;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/position_ledger.sv
// Per-stock positions and cooldowns plus the cash balance. Updated only when
// an order is accepted on the output handshake; cooldowns tick down every cycle.
module position_ledger
    import trade_pkg::*;
#(
    parameter logic [CASH_W-1:0] INIT_CASH = 32'd100000,
    parameter int                COOLDOWN  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        commit_i,
    input  logic                        side_i,
    input  logic [ID_W-1:0]             id_i,
    input  logic [CASH_W-1:0]           cost_i,
    input  logic [ID_W-1:0]             lookup_id_i,
    output logic [POS_W-1:0]            pos_o,
    output logic                        cooldown_busy_o,
    output logic [CASH_W-1:0]           cash_o,
    output logic [NUM_STOCKS*POS_W-1:0] pos_all_o
);

    logic [NUM_STOCKS-1:0][POS_W-1:0] pos_q, pos_d;
    logic [NUM_STOCKS-1:0][CD_W-1:0]  cd_q, cd_d;
    logic [CASH_W-1:0]                cash_q, cash_d;
    logic [CASH_W:0]                  cash_sum;

    assign cash_sum = {1'b0, cash_q} + {1'b0, cost_i};

    always_comb begin
        pos_d  = pos_q;
        cd_d   = cd_q;
        cash_d = cash_q;
        for (int i = 0; i < NUM_STOCKS; i++) begin
            if (cd_q[i] != '0) begin
                cd_d[i] = cd_q[i] - CD_W'(1);
            end
        end
        // A fresh reload overrides this cycle's decrement for the traded stock.
        if (commit_i) begin
            cd_d[id_i] = CD_W'(COOLDOWN);
            if (side_i == SIDE_BUY) begin
                pos_d[id_i] = pos_q[id_i] + POS_W'(1);
                cash_d      = cash_q - cost_i;
            end else begin
                pos_d[id_i] = pos_q[id_i] - POS_W'(1);
                cash_d      = cash_sum[CASH_W] ? {CASH_W{1'b1}} : cash_sum[CASH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q  <= '0;
            cd_q   <= '0;
            cash_q <= INIT_CASH;
        end else begin
            pos_q  <= pos_d;
            cd_q   <= cd_d;
            cash_q <= cash_d;
        end
    end

    assign pos_o           = pos_q[lookup_id_i];
    assign cooldown_busy_o = (cd_q[lookup_id_i] != '0);
    assign cash_o          = cash_q;
    assign pos_all_o       = pos_q;

endmodule

// File: rtl/trade_order_manager.sv
// Turns registered EMA buy/sell pulses into lot-sized orders, checking funds,
// position limits and per-stock cooldown before presenting them downstream.
module trade_order_manager
    import trade_pkg::*;
#(
    parameter logic [CASH_W-1:0] INIT_CASH = 32'd100000,
    parameter int                LOT_SIZE  = 10,
    parameter int                MAX_POS   = 3,
    parameter int                COOLDOWN  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_en,
    input  logic [15:0]                 tick_in,
    input  logic                        buy_signal,
    input  logic                        sell_signal,
    output logic                        order_valid,
    input  logic                        order_ready,
    output logic                        order_side,
    output logic [ID_W-1:0]             order_stock,
    output logic [PRICE_W-1:0]          order_price,
    output logic [7:0]                  order_qty,
    output logic [CASH_W-1:0]           cash,
    output logic [CNT_W-1:0]            reject_count,
    output logic [CNT_W-1:0]            drop_count,
    output logic [1:0]                  dbg_state,
    output logic [NUM_STOCKS*POS_W-1:0] dbg_pos
);

    state_e              state_q;
    logic [ID_W-1:0]     align_id_q, req_id_q, order_stock_q;
    logic [PRICE_W-1:0]  align_price_q, req_price_q, order_price_q;
    logic                req_side_q, order_side_q, order_valid_q;
    logic [7:0]          order_qty_q;
    logic [CNT_W-1:0]    reject_q, drop_q;

    logic [POS_W-1:0]    lk_pos;
    logic                lk_busy;
    logic [CASH_W-1:0]   cash_w;
    logic [CASH_W-1:0]   check_cost, commit_cost;
    logic                pulse, commit, reject_now;

    assign pulse       = buy_signal | sell_signal;
    assign check_cost  = lot_cost(req_price_q, CASH_W'(LOT_SIZE));
    assign commit_cost = lot_cost(order_price_q, CASH_W'(LOT_SIZE));

    // Handshake: once order_valid rises the order_* fields stay frozen until the
    // cycle where order_valid & order_ready are both high; that edge is the
    // transfer, the ledger commits on it and valid drops the next cycle.
    assign commit = (state_q == ST_ISSUE) && order_valid_q && order_ready;

    assign reject_now = lk_busy
        || ((req_side_q == SIDE_BUY)  && ((lk_pos >= POS_W'(MAX_POS)) || (cash_w < check_cost)))
        || ((req_side_q == SIDE_SELL) && (lk_pos == '0));

    position_ledger #(
        .INIT_CASH (INIT_CASH),
        .COOLDOWN  (COOLDOWN)
    ) u_ledger (
        .clk             (clk),
        .rst             (rst),
        .commit_i        (commit),
        .side_i          (order_side_q),
        .id_i            (order_stock_q),
        .cost_i          (commit_cost),
        .lookup_id_i     (req_id_q),
        .pos_o           (lk_pos),
        .cooldown_busy_o (lk_busy),
        .cash_o          (cash_w),
        .pos_all_o       (dbg_pos)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            align_id_q    <= '0;
            align_price_q <= '0;
            req_id_q      <= '0;
            req_price_q   <= '0;
            req_side_q    <= SIDE_BUY;
            order_valid_q <= 1'b0;
            order_side_q  <= SIDE_BUY;
            order_stock_q <= '0;
            order_price_q <= '0;
            order_qty_q   <= '0;
            reject_q      <= '0;
            drop_q        <= '0;
        end else begin
            // Pulses refer to the tick of the previous cycle, so the FSM reads the old align regs.
            if (tick_en) begin
                align_id_q    <= tick_in[15:14];
                align_price_q <= tick_in[13:0];
            end
            case (state_q)
                ST_IDLE: begin
                    if (buy_signal ^ sell_signal) begin
                        req_side_q  <= sell_signal ? SIDE_SELL : SIDE_BUY;
                        req_id_q    <= align_id_q;
                        req_price_q <= align_price_q;
                        state_q     <= ST_CHECK;
                    end else if (buy_signal && sell_signal) begin
                        reject_q <= sat_inc(reject_q);
                    end
                end
                ST_CHECK: begin
                    if (pulse) begin
                        drop_q <= sat_inc(drop_q);
                    end
                    if (reject_now) begin
                        reject_q <= sat_inc(reject_q);
                        state_q  <= ST_IDLE;
                    end else begin
                        order_valid_q <= 1'b1;
                        order_side_q  <= req_side_q;
                        order_stock_q <= req_id_q;
                        order_price_q <= req_price_q;
                        order_qty_q   <= 8'(LOT_SIZE);
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (pulse) begin
                        drop_q <= sat_inc(drop_q);
                    end
                    if (order_ready) begin
                        order_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    order_valid_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign order_valid  = order_valid_q;
    assign order_side   = order_side_q;
    assign order_stock  = order_stock_q;
    assign order_price  = order_price_q;
    assign order_qty    = order_qty_q;
    assign cash         = cash_w;
    assign reject_count = reject_q;
    assign drop_count   = drop_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_trade_order_manager.sv
// Directed bench for trade_order_manager: expected orders go into a queue,
// a negedge monitor pops them on every accepted handshake.
module tb_trade_order_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_en;
    logic [15:0] tick_in;
    logic        buy_signal;
    logic        sell_signal;
    logic        order_valid;
    logic        order_ready;
    logic        order_side;
    logic [1:0]  order_stock;
    logic [13:0] order_price;
    logic [7:0]  order_qty;
    logic [31:0] cash;
    logic [15:0] reject_count;
    logic [15:0] drop_count;
    logic [1:0]  dbg_state;
    logic [15:0] dbg_pos;

    logic [24:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        hold_seen = 1'b0;
    logic [24:0] prev_ord = '0;

    trade_order_manager dut (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .tick_in      (tick_in),
        .buy_signal   (buy_signal),
        .sell_signal  (sell_signal),
        .order_valid  (order_valid),
        .order_ready  (order_ready),
        .order_side   (order_side),
        .order_stock  (order_stock),
        .order_price  (order_price),
        .order_qty    (order_qty),
        .cash         (cash),
        .reject_count (reject_count),
        .drop_count   (drop_count),
        .dbg_state    (dbg_state),
        .dbg_pos      (dbg_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    // Tick in one cycle, the registered pulse in the next.
    task automatic pulse(input logic [1:0] id, input logic [13:0] price,
                         input logic b, input logic s);
        tick_en     = 1'b1;
        tick_in     = {id, price};
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
        cyc();
        tick_en     = 1'b0;
        buy_signal  = b;
        sell_signal = s;
        cyc();
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
    endtask

    task automatic expect_order(input logic side, input logic [1:0] id, input logic [13:0] price);
        exp_q.push_back({side, id, price, 8'd10});
    endtask

    always @(negedge clk) begin
        logic [24:0] cur;
        logic [24:0] e;
        if (rst) begin
            hold_seen = 1'b0;
        end else begin
            cur = {order_side, order_stock, order_price, order_qty};
            if (order_valid && hold_seen) check("order_stable", 32'(cur), 32'(prev_ord));
            if (order_valid && order_ready) begin
                if (exp_q.size() == 0) begin
                    check("order_unexpected", 32'(cur), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("order", 32'(cur), 32'(e));
                end
            end
            hold_seen = order_valid && !order_ready;
            prev_ord  = cur;
        end
    end

    initial begin
        rst         = 1'b1;
        tick_en     = 1'b0;
        tick_in     = '0;
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
        order_ready = 1'b0;
        idle(3);
        check("rst_valid", 32'(order_valid), 32'd0);
        check("rst_cash", cash, 32'd100000);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_counts", {reject_count, drop_count}, 32'd0);
        check("rst_order", 32'({order_side, order_stock, order_price, order_qty}), 32'd0);
        rst = 1'b0;
        order_ready = 1'b1;
        idle(2);

        // 1: buy id1 @750, latency and ledger update
        expect_order(1'b0, 2'd1, 14'd750);
        pulse(2'd1, 14'd750, 1'b1, 1'b0);
        check("t1_state_check", 32'(dbg_state), 32'd1);
        check("t1_valid_early", 32'(order_valid), 32'd0);
        cyc();
        check("t1_valid_high", 32'(order_valid), 32'd1);
        cyc();
        check("t1_valid_low", 32'(order_valid), 32'd0);
        idle(2);
        check("t1_cash", cash, 32'd92500);
        check("t1_pos", 32'(dbg_pos), 32'h0010);

        // 2: sell with no position
        pulse(2'd2, 14'd500, 1'b0, 1'b1);
        idle(4);
        check("t2_reject", 32'(reject_count), 32'd1);
        check("t2_cash", cash, 32'd92500);

        // 3: unfundable buy, then simultaneous buy+sell
        pulse(2'd0, 14'd10878, 1'b1, 1'b0);
        idle(4);
        check("t3_reject_funds", 32'(reject_count), 32'd2);
        pulse(2'd0, 14'd100, 1'b1, 1'b1);
        idle(4);
        check("t3_reject_both", 32'(reject_count), 32'd3);
        check("t3_pos", 32'(dbg_pos), 32'h0010);

        // 4: back-pressure for 5 cycles, second buy dropped
        order_ready = 1'b0;
        expect_order(1'b0, 2'd2, 14'd1000);
        pulse(2'd2, 14'd1000, 1'b1, 1'b0);
        pulse(2'd0, 14'd200, 1'b1, 1'b0);
        idle(3);
        check("t4_valid_held", 32'(order_valid), 32'd1);
        check("t4_state_issue", 32'(dbg_state), 32'd2);
        order_ready = 1'b1;
        idle(4);
        check("t4_drop", 32'(drop_count), 32'd1);
        check("t4_cash", cash, 32'd82500);
        check("t4_pos", 32'(dbg_pos), 32'h0110);

        // 5: cooldown blocks a quick repeat, later repeat succeeds
        expect_order(1'b0, 2'd1, 14'd750);
        pulse(2'd1, 14'd750, 1'b1, 1'b0);
        idle(2);
        pulse(2'd1, 14'd750, 1'b1, 1'b0);
        idle(4);
        check("t5_reject_cd", 32'(reject_count), 32'd4);
        check("t5_cash_mid", cash, 32'd75000);
        idle(6);
        expect_order(1'b0, 2'd1, 14'd750);
        pulse(2'd1, 14'd750, 1'b1, 1'b0);
        idle(4);
        check("t5_cash", cash, 32'd67500);
        check("t5_pos", 32'(dbg_pos), 32'h0130);

        // 6: fresh start, fill id3 to MAX_POS, sell one, reset mid-issue
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        for (int k = 0; k < 3; k++) begin
            expect_order(1'b0, 2'd3, 14'd2412);
            pulse(2'd3, 14'd2412, 1'b1, 1'b0);
            idle(12);
        end
        pulse(2'd3, 14'd2412, 1'b1, 1'b0);
        idle(12);
        check("t6_reject_max", 32'(reject_count), 32'd1);
        check("t6_cash_full", cash, 32'd27640);
        check("t6_pos_full", 32'(dbg_pos), 32'h3000);
        expect_order(1'b1, 2'd3, 14'd2412);
        pulse(2'd3, 14'd2412, 1'b0, 1'b1);
        idle(12);
        check("t6_cash_sell", cash, 32'd51760);
        check("t6_pos_sell", 32'(dbg_pos), 32'h2000);

        order_ready = 1'b0;
        pulse(2'd3, 14'd2412, 1'b1, 1'b0);
        cyc();
        check("t6_valid_pre_rst", 32'(order_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(order_valid), 32'd0);
        check("t6_rst_cash", cash, 32'd100000);
        check("t6_rst_pos", 32'(dbg_pos), 32'h0000);
        check("t6_rst_state", 32'(dbg_state), 32'd0);
        idle(2);
        rst = 1'b0;
        order_ready = 1'b1;
        idle(4);
        check("t6_post_cash", cash, 32'd100000);
        check("t6_post_valid", 32'(order_valid), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
